mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have ports core_req/core_we, input, 1 each, core access request and write select.
REQ-004 SHALL have ports core_addr/core_wdata, input, 32 each, core byte address and store data.
REQ-005 SHALL have ports core_rdata, output, 32, and core_ready, output, 1: core load data and completion pulse.
REQ-006 SHALL have ports ldr_req/ldr_we, input, 1, and ldr_addr/ldr_wdata, input, 32: loader/DMA port, same meaning as core.
REQ-007 SHALL have ports ldr_rdata, output, 32, and ldr_ready, output, 1.
REQ-008 SHALL have ports mem_addr/mem_wdata, output, 32, mem_we, output, 1, and mem_rdata, input, 32: single-port memory with 1-cycle synchronous read.
REQ-009 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-010 SHALL implement FSM states IDLE, ACCESS, RESP; the granted requester (CORE or LDR) SHALL be registered on leaving IDLE.
REQ-011 IDLE: no request -> IDLE; one request -> grant it, go ACCESS; both -> per REQ-020/REQ-021.
REQ-012 ACCESS: mem_addr/mem_wdata SHALL equal the granted requester's addr/wdata, and mem_we SHALL equal its we; go RESP unconditionally.
REQ-013 Outside ACCESS: mem_we SHALL be 0; mem_addr/mem_wdata SHALL hold their last ACCESS values.
REQ-014 RESP: mem_rdata SHALL be captured into the granted port's rdata register; that port's ready SHALL be 1 for exactly this cycle; go IDLE.
REQ-015 Latency: request sampled in IDLE at cycle N -> memory access at N+1 -> ready at N+2; reads and writes identical.
REQ-016 Maximum throughput SHALL be one access per 3 cycles; a request held high during RESP SHALL be re-arbitrated in the following IDLE.
REQ-017 The non-granted port's ready SHALL stay 0 and its rdata SHALL be unchanged.
REQ-018 Requesters SHALL hold req/we/addr/wdata stable until ready; deassertion of req after grant SHALL NOT abort the access, and ready SHALL still pulse.
REQ-019 Write accesses SHALL leave the rdata of the granted port unchanged.

Configuration
REQ-020 With ARB_ROUND_ROBIN_EN defined: on simultaneous requests, grant the requester not served last (last_grant register, updated on every grant).
REQ-021 Without ARB_ROUND_ROBIN_EN: on simultaneous requests, CORE SHALL always win; no last_grant register exists.

Reset
REQ-022 rst high SHALL force, asynchronously: state IDLE, mem_we 0, mem_addr 0, mem_wdata 0, core_ready/ldr_ready 0, core_rdata/ldr_rdata 0, busy 0, and last_grant LDR, so that CORE wins the first tie.
REQ-023 Reset during ACCESS or RESP SHALL abort the transaction with no ready pulse; after release, the FSM SHALL restart from IDLE.

Structure
REQ-024 State encoding (2-bit) and requester IDs (REQ_CORE=0, REQ_LDR=1) SHALL live in shared package arb_pkg.
REQ-025 Tie-break logic SHALL be a combinational sub-module arb_pick (inputs: both reqs and last_grant; output: grant ID), with its body selected by ARB_ROUND_ROBIN_EN.

Verification
REQ-026 Core read: core_req=1, core_addr=0x10, mem returns 0xDEADBEEF -> mem_addr=0x10 at N+1, core_ready=1 with core_rdata=0xDEADBEEF at N+2.
REQ-027 Loader write: ldr_we=1, ldr_addr=0x40, ldr_wdata=0x12345678 -> mem_we=1 for exactly one cycle (N+1), ldr_ready at N+2, core_ready stays 0.
REQ-028 Tie, both ports held high for 4 grants -> round-robin: grant order CORE, LDR, CORE, LDR; fixed priority: CORE every time.
REQ-029 Reset during ACCESS -> mem_we drops the same cycle, no ready pulse, busy 0; a new request is served normally after release.
REQ-030 core_req dropped in ACCESS -> core_ready still pulses at N+2; FSM returns to IDLE with busy 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM state encoding and requester IDs.
package arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   typedef enum logic {
      REQ_CORE = 1'b0,
      REQ_LDR  = 1'b1
   } req_id_t;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 32;

   function automatic req_id_t other_id(input req_id_t id);
      return (id == REQ_CORE) ? REQ_LDR : REQ_CORE;
   endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational tie-break between core and loader requests.
// ARB_ROUND_ROBIN_EN selects round-robin on ties; otherwise the core always wins.
module arb_pick
   import arb_pkg::*;
(
   input  logic    core_req,
   input  logic    ldr_req,
   input  req_id_t last_grant,
   output req_id_t grant
);

`ifdef ARB_ROUND_ROBIN_EN
   always_comb begin
      grant = REQ_CORE;
      if (core_req && ldr_req) begin
         grant = other_id(last_grant);
      end else if (ldr_req) begin
         grant = REQ_LDR;
      end
   end
`else
   // Fixed priority has no history; the port is kept so both builds share one interface.
   logic unused_last_grant;
   assign unused_last_grant = last_grant;

   always_comb begin
      grant = REQ_CORE;
      if (ldr_req && !core_req) begin
         grant = REQ_LDR;
      end
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (core / loader) arbiter in front of a single-port, 1-cycle-read memory.
// Optional macro ARB_ROUND_ROBIN_EN enables round-robin tie-breaking.
module mem_arbiter
   import arb_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              core_req,
   input  logic              core_we,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wdata,
   output logic [DATA_W-1:0] core_rdata,
   output logic              core_ready,
   input  logic              ldr_req,
   input  logic              ldr_we,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [DATA_W-1:0] ldr_wdata,
   output logic [DATA_W-1:0] ldr_rdata,
   output logic              ldr_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   state_t            state_reg, state_next;
   req_id_t           grant_reg, grant_next;
   req_id_t           pick;
   req_id_t           last_grant;
   logic [ADDR_W-1:0] addr_hold_reg;
   logic [DATA_W-1:0] wdata_hold_reg;
   logic              acc_we_reg;
   logic [DATA_W-1:0] core_rdata_reg;
   logic [DATA_W-1:0] ldr_rdata_reg;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              sel_we;
   logic              any_req;

   assign any_req   = core_req | ldr_req;
   assign sel_addr  = (grant_reg == REQ_CORE) ? core_addr  : ldr_addr;
   assign sel_wdata = (grant_reg == REQ_CORE) ? core_wdata : ldr_wdata;
   assign sel_we    = (grant_reg == REQ_CORE) ? core_we    : ldr_we;

`ifdef ARB_ROUND_ROBIN_EN
   req_id_t last_grant_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant_reg <= REQ_LDR;
      end else if (state_reg == ST_IDLE && any_req) begin
         last_grant_reg <= pick;
      end
   end

   assign last_grant = last_grant_reg;
`else
   assign last_grant = REQ_LDR;
`endif

   arb_pick u_pick (
      .core_req   (core_req),
      .ldr_req    (ldr_req),
      .last_grant (last_grant),
      .grant      (pick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         grant_reg <= REQ_CORE;
      end else begin
         state_reg <= state_next;
         grant_reg <= grant_next;
      end
   end

   // Memory address/data hold their last access values; rdata is captured only on reads.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_hold_reg  <= '0;
         wdata_hold_reg <= '0;
         acc_we_reg     <= 1'b0;
         core_rdata_reg <= '0;
         ldr_rdata_reg  <= '0;
      end else begin
         if (state_reg == ST_ACCESS) begin
            addr_hold_reg  <= sel_addr;
            wdata_hold_reg <= sel_wdata;
            acc_we_reg     <= sel_we;
         end
         if (state_reg == ST_RESP && !acc_we_reg) begin
            if (grant_reg == REQ_CORE) begin
               core_rdata_reg <= mem_rdata;
            end else begin
               ldr_rdata_reg <= mem_rdata;
            end
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      grant_next = grant_reg;
      mem_addr   = addr_hold_reg;
      mem_wdata  = wdata_hold_reg;
      mem_we     = 1'b0;
      core_ready = 1'b0;
      ldr_ready  = 1'b0;
      core_rdata = core_rdata_reg;
      ldr_rdata  = ldr_rdata_reg;
      busy       = (state_reg != ST_IDLE);

      case (state_reg)
         ST_IDLE: begin
            if (any_req) begin
               grant_next = pick;
               state_next = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            mem_addr   = sel_addr;
            mem_wdata  = sel_wdata;
            mem_we     = sel_we;
            state_next = ST_RESP;
         end
         ST_RESP: begin
            // Load data is forwarded straight from memory so it is visible with ready.
            if (grant_reg == REQ_CORE) begin
               core_ready = 1'b1;
               if (!acc_we_reg) core_rdata = mem_rdata;
            end else begin
               ldr_ready = 1'b1;
               if (!acc_we_reg) ldr_rdata = mem_rdata;
            end
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of arbitration, memory contents and rdata.
module tb_mem_arbiter;
   import arb_pkg::*;

`ifdef ARB_ROUND_ROBIN_EN
   localparam bit RR_EN = 1'b1;
`else
   localparam bit RR_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        core_req, core_we, ldr_req, ldr_we;
   logic [31:0] core_addr, core_wdata, ldr_addr, ldr_wdata;
   logic [31:0] core_rdata, ldr_rdata;
   logic        core_ready, ldr_ready;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_we, busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .core_req   (core_req),
      .core_we    (core_we),
      .core_addr  (core_addr),
      .core_wdata (core_wdata),
      .core_rdata (core_rdata),
      .core_ready (core_ready),
      .ldr_req    (ldr_req),
      .ldr_we     (ldr_we),
      .ldr_addr   (ldr_addr),
      .ldr_wdata  (ldr_wdata),
      .ldr_rdata  (ldr_rdata),
      .ldr_ready  (ldr_ready),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_we     (mem_we),
      .mem_rdata  (mem_rdata),
      .busy       (busy)
   );

   function automatic logic [31:0] init_val(input logic [7:0] i);
      return (i == 8'd4) ? 32'hDEADBEEF : {i, 8'h5A, ~i, 8'hC3};
   endfunction

   // External single-port memory, 1-cycle synchronous read.
   logic [31:0] mem [0:255];
   bit          mem_valid [0:255];
   always @(posedge clk) begin
      mem_rdata <= mem_valid[mem_addr[9:2]] ? mem[mem_addr[9:2]] : init_val(mem_addr[9:2]);
      if (mem_we) begin
         mem[mem_addr[9:2]]       <= mem_wdata;
         mem_valid[mem_addr[9:2]] <= 1'b1;
      end
   end

   // Reference model state
   logic [31:0] ref_mem [0:255];
   logic [31:0] exp_rdata [2];
   int          exp_last;
   logic        t_we [2];
   logic [31:0] t_addr [2];
   logic [31:0] t_wdata [2];

   function automatic int pick_winner(input bit c, input bit l);
      if (c && l) return RR_EN ? ((exp_last == 0) ? 1 : 0) : 0;
      return c ? 0 : 1;
   endfunction

   task automatic apply(input int p, input logic r);
      if (p == 0) begin
         core_req = r; core_we = t_we[0]; core_addr = t_addr[0]; core_wdata = t_wdata[0];
      end else begin
         ldr_req = r; ldr_we = t_we[1]; ldr_addr = t_addr[1]; ldr_wdata = t_wdata[1];
      end
   endtask

   task automatic model_reset();
      exp_rdata[0] = '0;
      exp_rdata[1] = '0;
      exp_last     = 1;
   endtask

   task automatic rand_txn(input int p);
      logic [7:0] idx;
      idx        = 8'($urandom_range(0, 255));
      t_we[p]    = 1'($urandom_range(0, 1));
      t_addr[p]  = {22'd0, idx, 2'b00};
      t_wdata[p] = $urandom;
   endtask

   // One granted access: entered in an IDLE cycle (#1 after its edge) with requests set up.
   task automatic run_round(input int w, input bit drop);
      logic [1:0] exp_rdy;
      exp_rdy = (w == 0) ? 2'b10 : 2'b01;
      @(posedge clk); #1;
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL access_busy: got %b want 1", busy); end
      n_checks++;
      if (mem_addr !== t_addr[w]) begin n_fail++; $display("FAIL access_addr: got %08h want %08h", mem_addr, t_addr[w]); end
      n_checks++;
      if (mem_wdata !== t_wdata[w]) begin n_fail++; $display("FAIL access_wdata: got %08h want %08h", mem_wdata, t_wdata[w]); end
      n_checks++;
      if (mem_we !== t_we[w]) begin n_fail++; $display("FAIL access_we: got %b want %b", mem_we, t_we[w]); end
      n_checks++;
      if ({core_ready, ldr_ready} !== 2'b00) begin n_fail++; $display("FAIL access_ready: got %b want 00", {core_ready, ldr_ready}); end
      if (t_we[w]) ref_mem[t_addr[w][9:2]] = t_wdata[w];
      else         exp_rdata[w] = ref_mem[t_addr[w][9:2]];
      exp_last = w;
      @(posedge clk); #1;
      n_checks++;
      if ({core_ready, ldr_ready} !== exp_rdy) begin n_fail++; $display("FAIL resp_ready: got %b want %b", {core_ready, ldr_ready}, exp_rdy); end
      n_checks++;
      if (core_rdata !== exp_rdata[0]) begin n_fail++; $display("FAIL resp_core_rdata: got %08h want %08h", core_rdata, exp_rdata[0]); end
      n_checks++;
      if (ldr_rdata !== exp_rdata[1]) begin n_fail++; $display("FAIL resp_ldr_rdata: got %08h want %08h", ldr_rdata, exp_rdata[1]); end
      n_checks++;
      if (mem_we !== 1'b0) begin n_fail++; $display("FAIL resp_we: got %b want 0", mem_we); end
      $display("txn %0s %0s addr=%08h wdata=%08h rdata=%08h", (w == 0) ? "CORE" : "LDR",
               t_we[w] ? "WR" : "RD", t_addr[w], t_wdata[w], exp_rdata[w]);
      if (drop) apply(w, 1'b0);
      @(posedge clk); #1;
      n_checks++;
      if (busy !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL idle_state: busy=%b we=%b want 0 0", busy, mem_we); end
      n_checks++;
      if ({core_ready, ldr_ready} !== 2'b00) begin n_fail++; $display("FAIL idle_ready: got %b want 00", {core_ready, ldr_ready}); end
      n_checks++;
      if (mem_addr !== t_addr[w] || mem_wdata !== t_wdata[w]) begin
         n_fail++; $display("FAIL idle_hold: got %08h/%08h want %08h/%08h", mem_addr, mem_wdata, t_addr[w], t_wdata[w]);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
      ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0;
      for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({busy, mem_we, core_ready, ldr_ready} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_ctrl: got %b want 0000", {busy, mem_we, core_ready, ldr_ready});
      end
      n_checks++;
      if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_mem: got %08h/%08h want 0/0", mem_addr, mem_wdata); end
      n_checks++;
      if (core_rdata !== 32'd0 || ldr_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %08h/%08h want 0/0", core_rdata, ldr_rdata); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_tie();
      t_we[0] = 0; t_addr[0] = 32'h0000_0080; t_wdata[0] = 32'h1111_1111;
      t_we[1] = 0; t_addr[1] = 32'h0000_00C0; t_wdata[1] = 32'h2222_2222;
      apply(0, 1'b1);
      apply(1, 1'b1);
      for (int k = 0; k < 4; k++) run_round(RR_EN ? (k % 2) : 0, 1'b0);
      apply(0, 1'b0);
      apply(1, 1'b0);
      @(posedge clk); #1;
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL tie_release_busy: got %b want 0", busy); end
   endtask

   task automatic test_core_read();
      t_we[0] = 0; t_addr[0] = 32'h0000_0010; t_wdata[0] = 32'h0;
      apply(0, 1'b1);
      run_round(0, 1'b1);
      n_checks++;
      if (core_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL core_read_data: got %08h want deadbeef", core_rdata); end
   endtask

   task automatic test_ldr_write();
      t_we[1] = 1; t_addr[1] = 32'h0000_0040; t_wdata[1] = 32'h1234_5678;
      apply(1, 1'b1);
      run_round(1, 1'b1);
      t_we[0] = 0; t_addr[0] = 32'h0000_0040; t_wdata[0] = 32'h0;
      apply(0, 1'b1);
      run_round(0, 1'b1);
      n_checks++;
      if (core_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL ldr_write_readback: got %08h want 12345678", core_rdata); end
   endtask

   task automatic test_drop();
      rand_txn(0);
      t_we[0] = 0;
      apply(0, 1'b1);
      @(posedge clk); #1;
      n_checks++;
      if (mem_addr !== t_addr[0] || busy !== 1'b1) begin n_fail++; $display("FAIL drop_access: got %08h busy=%b want %08h 1", mem_addr, busy, t_addr[0]); end
      apply(0, 1'b0);
      exp_rdata[0] = ref_mem[t_addr[0][9:2]];
      exp_last = 0;
      @(posedge clk); #1;
      n_checks++;
      if (core_ready !== 1'b1 || core_rdata !== exp_rdata[0]) begin
         n_fail++; $display("FAIL drop_resp: ready=%b rdata=%08h want 1 %08h", core_ready, core_rdata, exp_rdata[0]);
      end
      $display("txn CORE RD (dropped) addr=%08h rdata=%08h", t_addr[0], exp_rdata[0]);
      repeat (2) begin
         @(posedge clk); #1;
         n_checks++;
         if (busy !== 1'b0 || core_ready !== 1'b0) begin n_fail++; $display("FAIL drop_idle: busy=%b ready=%b want 0 0", busy, core_ready); end
      end
   endtask

   task automatic test_reset_abort();
      t_we[0] = 1; t_addr[0] = 32'h0000_0020; t_wdata[0] = 32'hCAFE_F00D;
      apply(0, 1'b1);
      @(posedge clk); #1;
      n_checks++;
      if (mem_we !== 1'b1) begin n_fail++; $display("FAIL abort_pre_we: got %b want 1", mem_we); end
      rst = 1'b1;
      #1;
      model_reset();
      n_checks++;
      if ({mem_we, busy, core_ready, ldr_ready} !== 4'b0000 || mem_addr !== 32'd0) begin
         n_fail++; $display("FAIL abort_async: got %b addr=%08h want 0000 0", {mem_we, busy, core_ready, ldr_ready}, mem_addr);
      end
      apply(0, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
         n_checks++;
         if ({busy, core_ready, ldr_ready} !== 3'b000) begin n_fail++; $display("FAIL abort_after: got %b want 000", {busy, core_ready, ldr_ready}); end
      end
      $display("txn CORE WR (aborted) addr=%08h", t_addr[0]);
      t_we[1] = 0; t_addr[1] = 32'h0000_0020; t_wdata[1] = 32'h0;
      apply(1, 1'b1);
      run_round(1, 1'b1);
   endtask

   task automatic test_random();
      bit pend [2];
      int mask, w;
      for (int it = 0; it < 40; it++) begin
         mask = $urandom_range(1, 3);
         for (int p = 0; p < 2; p++) begin
            pend[p] = mask[p];
            if (pend[p]) begin
               rand_txn(p);
               apply(p, 1'b1);
            end
         end
         while (pend[0] || pend[1]) begin
            w = pick_winner(pend[0], pend[1]);
            run_round(w, 1'b1);
            pend[w] = 1'b0;
         end
      end
   endtask

   initial begin
      test_reset();
      test_tie();
      test_core_read();
      test_ldr_write();
      test_drop();
      test_reset_abort();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
